// File: rtl/ps2_key_tracker_if.sv
// Event stream between the PS/2 key tracker and its consumer.
// The master drives the head-of-FIFO event; the slave drives the pop strobe.
interface ps2_key_tracker_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic       evt_make;
  logic       evt_repeat;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_make,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_make,
    input  evt_repeat,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: decodes E0/F0 prefixes, keeps a table of held
// keys and queues press/release events in a first-word fall-through FIFO.
// Optional feature macro: KEY_TYPEMATIC_EN (repeat makes of a held key are
// queued with evt_repeat=1 instead of being discarded).
module ps2_key_tracker #(
  parameter int unsigned MAX_KEYS   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ready,
  input  logic [7:0]                   data,
  ps2_key_tracker_if.master            evt,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_count,
  output logic                         any_pressed,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int unsigned CW = $clog2(MAX_KEYS + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned KW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e state_q, state_d;

  logic       do_make;
  logic       do_break;
  logic [8:0] key;

  // Key table
  logic [MAX_KEYS-1:0] slot_valid_q;
  logic [8:0]          slot_key_q [MAX_KEYS];
  logic                hit;
  logic [KW-1:0]       hit_idx;
  logic                has_free;
  logic [KW-1:0]       free_idx;
  logic                tbl_set;
  logic                tbl_clr;
  logic                drop_tbl;

  // Event FIFO
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [8:0]  mem_key  [FIFO_DEPTH];
  logic        mem_make [FIFO_DEPTH];
  logic        fifo_empty;
  logic        fifo_full;
  logic        push_req;
  logic        push_make;
  logic        push;
  logic        pop;
  logic        drop_fifo;
`ifdef KEY_TYPEMATIC_EN
  logic        mem_rep [FIFO_DEPTH];
  logic        push_rep;
`endif

  // Prefix state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Prefix decode: only the final byte of a sequence produces a make/break
  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    key      = {1'b0, data};
    if (ready) begin
      unique case (state_q)
        StIdle: begin
          if (data == 8'hE0)      state_d = StExt;
          else if (data == 8'hF0) state_d = StBrk;
          else                    do_make = 1'b1;
        end
        StExt: begin
          if (data == 8'hF0)      state_d = StExtBrk;
          else if (data == 8'hE0) state_d = StExt;
          else begin
            do_make = 1'b1;
            key     = {1'b1, data};
            state_d = StIdle;
          end
        end
        StBrk: begin
          // E0 after F0 is a protocol error; restart as an extended sequence
          if (data == 8'hE0) state_d = StExt;
          else begin
            do_break = 1'b1;
            state_d  = StIdle;
          end
        end
        StExtBrk: begin
          if (data == 8'hE0 || data == 8'hF0) state_d = StExt;
          else begin
            do_break = 1'b1;
            key      = {1'b1, data};
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Parallel table lookup; descending scan so the lowest index wins
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (slot_valid_q[i] && slot_key_q[i] == key) begin
        hit     = 1'b1;
        hit_idx = KW'(i);
      end
      if (!slot_valid_q[i]) begin
        has_free = 1'b1;
        free_idx = KW'(i);
      end
    end
  end

  // Held-key population count
  always_comb begin
    held_count = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (slot_valid_q[i]) held_count = held_count + CW'(1);
    end
    any_pressed = (held_count != '0);
  end

  // Event generation and table actions
  always_comb begin
    push_req  = 1'b0;
    push_make = 1'b0;
    tbl_set   = 1'b0;
    tbl_clr   = 1'b0;
    drop_tbl  = 1'b0;
`ifdef KEY_TYPEMATIC_EN
    push_rep  = 1'b0;
`endif
    if (do_make) begin
      if (hit) begin
`ifdef KEY_TYPEMATIC_EN
        push_req  = 1'b1;
        push_make = 1'b1;
        push_rep  = 1'b1;
`endif
      end else if (has_free) begin
        tbl_set   = 1'b1;
        push_req  = 1'b1;
        push_make = 1'b1;
      end else begin
        drop_tbl = 1'b1;
      end
    end
    // Break of a key not held is silently ignored
    if (do_break && hit) begin
      tbl_clr  = 1'b1;
      push_req = 1'b1;
    end
  end

  // Table update, independent of FIFO state
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      for (int i = 0; i < MAX_KEYS; i++) slot_key_q[i] <= '0;
    end else begin
      if (tbl_set) begin
        slot_valid_q[free_idx] <= 1'b1;
        slot_key_q[free_idx]   <= key;
      end
      if (tbl_clr) slot_valid_q[hit_idx] <= 1'b0;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt.evt_ready;
  // A same-cycle pop frees the slot the push needs
  assign push       = push_req && (!fifo_full || pop);
  assign drop_fifo  = push_req && fifo_full && !pop;

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_key[wr_ptr_q[AW-1:0]]  <= key;
      mem_make[wr_ptr_q[AW-1:0]] <= push_make;
`ifdef KEY_TYPEMATIC_EN
      mem_rep[wr_ptr_q[AW-1:0]]  <= push_rep;
`endif
    end
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (drop_tbl || drop_fifo) overflow <= 1'b1;
    else if (ovf_clr)               overflow <= 1'b0;
  end

  // Head-of-FIFO outputs, forced to zero when empty
  always_comb begin
    evt.evt_valid  = !fifo_empty;
    evt.evt_code   = fifo_empty ? 9'd0 : mem_key[rd_ptr_q[AW-1:0]];
    evt.evt_make   = fifo_empty ? 1'b0 : mem_make[rd_ptr_q[AW-1:0]];
`ifdef KEY_TYPEMATIC_EN
    evt.evt_repeat = fifo_empty ? 1'b0 : mem_rep[rd_ptr_q[AW-1:0]];
`else
    evt.evt_repeat = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a vector table of scan bytes with the
// expected head event, held count and overflow after each byte, plus
// hand-written sequences for FIFO saturation, overflow clear and mid-prefix reset.
module tb_ps2_key_tracker;

`ifdef KEY_TYPEMATIC_EN
  localparam bit TYPM = 1'b1;
`else
  localparam bit TYPM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic [2:0] held_count;
  logic       any_pressed;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  ps2_key_tracker_if evt_bus ();

  ps2_key_tracker #(
    .MAX_KEYS   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .data        (data),
    .evt         (evt_bus),
    .held_count  (held_count),
    .any_pressed (any_pressed),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [8:0] code;
    logic       make;
    logic       rep;
    int         held;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] d, input logic v, input logic [8:0] c,
                     input logic m, input logic r, input int h, input logic o);
    vec_t e;
    e.data = d; e.valid = v; e.code = c; e.make = m; e.rep = r; e.held = h; e.ovf = o;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Strobe one byte; returns at the next falling edge with outputs settled
  task automatic send_byte(input logic [7:0] b, input logic er, input logic oc);
    @(negedge clk);
    ready = 1'b1;
    data = b;
    evt_bus.evt_ready = er;
    ovf_clr = oc;
    @(negedge clk);
    ready = 1'b0;
    evt_bus.evt_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic pop_one();
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    evt_bus.evt_ready = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [8:0] c, input logic m);
    chk({nm, " valid"}, 32'(evt_bus.evt_valid), 32'd1);
    chk({nm, " code"}, 32'(evt_bus.evt_code), 32'(c));
    chk({nm, " make"}, 32'(evt_bus.evt_make), 32'(m));
    pop_one();
  endtask

  logic [8:0] q_code [8];
  logic       q_make [8];

  initial begin
    rst = 1'b1; ready = 1'b0; data = 8'h00; ovf_clr = 1'b0; evt_bus.evt_ready = 1'b0;

    // Test 1: make/break of a plain key
    add(8'h1C, 1, 9'h01C, 1, 0, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'h1C, 1, 9'h01C, 0, 0, 0, 0);
    // Test 2: extended key is distinct from the plain one
    add(8'hE0, 0, 9'h000, 0, 0, 0, 0);
    add(8'h75, 1, 9'h175, 1, 0, 1, 0);
    add(8'h75, 1, 9'h075, 1, 0, 2, 0);
    add(8'hE0, 0, 9'h000, 0, 0, 2, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 2, 0);
    add(8'h75, 1, 9'h175, 0, 0, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'h75, 1, 9'h075, 0, 0, 0, 0);
    // Test 5: typematic repeats
    add(8'h1C, 1, 9'h01C, 1, 0, 1, 0);
    add(8'h1C, TYPM, TYPM ? 9'h01C : 9'h000, TYPM, TYPM, 1, 0);
    add(8'h1C, TYPM, TYPM ? 9'h01C : 9'h000, TYPM, TYPM, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'h1C, 1, 9'h01C, 0, 0, 0, 0);
    // Protocol-error restarts: F0 E0 75 is an extended make
    add(8'hF0, 0, 9'h000, 0, 0, 0, 0);
    add(8'hE0, 0, 9'h000, 0, 0, 0, 0);
    add(8'h75, 1, 9'h175, 1, 0, 1, 0);
    // E0 F0 F0 F0 75: EXT_BRK restarts to EXT, then F0 re-enters EXT_BRK
    add(8'hE0, 0, 9'h000, 0, 0, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'hF0, 0, 9'h000, 0, 0, 1, 0);
    add(8'h75, 1, 9'h175, 0, 0, 0, 0);
    // Break of a key not held: no event, no overflow
    add(8'hF0, 0, 9'h000, 0, 0, 0, 0);
    add(8'h33, 0, 9'h000, 0, 0, 0, 0);
    // Test 3: table full drop and slot reuse
    add(8'h1C, 1, 9'h01C, 1, 0, 1, 0);
    add(8'h1B, 1, 9'h01B, 1, 0, 2, 0);
    add(8'h23, 1, 9'h023, 1, 0, 3, 0);
    add(8'h2B, 1, 9'h02B, 1, 0, 4, 0);
    add(8'h34, 0, 9'h000, 0, 0, 4, 1);
    add(8'hF0, 0, 9'h000, 0, 0, 4, 1);
    add(8'h1B, 1, 9'h01B, 0, 0, 3, 1);
    add(8'h34, 1, 9'h034, 1, 0, 4, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset evt_valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("reset evt_code", 32'(evt_bus.evt_code), 32'd0);
    chk("reset held_count", 32'(held_count), 32'd0);
    chk("reset any_pressed", 32'(any_pressed), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset evt_repeat", 32'(evt_bus.evt_repeat), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].data, 1'b0, 1'b0);
      chk($sformatf("vec%0d valid", i), 32'(evt_bus.evt_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d code", i), 32'(evt_bus.evt_code), 32'(vecs[i].code));
        chk($sformatf("vec%0d make", i), 32'(evt_bus.evt_make), 32'(vecs[i].make));
        chk($sformatf("vec%0d repeat", i), 32'(evt_bus.evt_repeat), 32'(vecs[i].rep));
      end
      chk($sformatf("vec%0d held", i), 32'(held_count), 32'(vecs[i].held));
      chk($sformatf("vec%0d any", i), 32'(any_pressed), 32'(vecs[i].held != 0));
      chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      if (evt_bus.evt_valid) pop_one();
    end

    // Drop on a full table wins over a same-cycle clear
    send_byte(8'h3C, 1'b0, 1'b1);
    chk("drop beats clear ovf", 32'(overflow), 32'd1);
    chk("drop beats clear valid", 32'(evt_bus.evt_valid), 32'd0);
    send_byte(8'hF0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    send_byte(8'h1C, 1'b0, 1'b0); pop_check("rel 1C", 9'h01C, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h23, 1'b0, 1'b0);
    pop_check("rel 23", 9'h023, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h2B, 1'b0, 1'b0);
    pop_check("rel 2B", 9'h02B, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h34, 1'b0, 1'b0);
    pop_check("rel 34", 9'h034, 1'b0);
    chk("table empty", 32'(held_count), 32'd0);

    // Test 4: nine events into an 8-deep FIFO with no consumer
    send_byte(8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1B, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h1B, 1'b0, 1'b0);
    send_byte(8'h23, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h23, 1'b0, 1'b0);
    send_byte(8'h2B, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h2B, 1'b0, 1'b0);
    chk("fifo 8 ovf still 0", 32'(overflow), 32'd0);
    send_byte(8'h34, 1'b0, 1'b0);
    chk("fifo full ovf", 32'(overflow), 32'd1);
    chk("fifo full held", 32'(held_count), 32'd1);
    chk("fifo full head code", 32'(evt_bus.evt_code), 32'h01C);
    chk("fifo full head make", 32'(evt_bus.evt_make), 32'd1);
    send_byte(8'hF0, 1'b0, 1'b1);
    chk("fifo ovf_clr", 32'(overflow), 32'd0);
    // Full FIFO with a same-cycle pop accepts the push
    send_byte(8'h34, 1'b1, 1'b0);
    chk("push with pop ovf", 32'(overflow), 32'd0);
    chk("push with pop held", 32'(held_count), 32'd0);
    q_code = '{9'h01C, 9'h01B, 9'h01B, 9'h023, 9'h023, 9'h02B, 9'h02B, 9'h034};
    q_make = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) pop_check($sformatf("fifo%0d", i), q_code[i], q_make[i]);
    chk("fifo drained", 32'(evt_bus.evt_valid), 32'd0);

    // Test 6: reset in the middle of a prefix discards it
    send_byte(8'hE0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h75, 1'b0, 1'b0);
    pop_check("post-reset make", 9'h075, 1'b1);
    chk("post-reset held", 32'(held_count), 32'd1);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h33, 1'b0, 1'b0);
    chk("stray break valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("stray break ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
